// File: rtl/mul_unit.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU), one shift-add step per clock.
// Optional `MUL_EARLY_OUT_EN: finish as soon as the remaining multiplier bits are zero.
//
// state  | meaning
// IDLE   | waiting for start; operand magnitudes and negate flag latched on start
// CALC   | one shift-add step per edge, busy=1
// DONE   | result valid, done pulses for one cycle
module mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] OP_MUL = 2'd0;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic              neg_q;
  logic [2*XLEN-1:0] acc;
  logic [5:0]        cnt;

  logic              rs1_signed, rs2_signed;
  logic              rs1_neg, rs2_neg;
  logic [XLEN-1:0]   rs1_mag, rs2_mag;
  logic [2*XLEN-1:0] addend, acc_nxt, product;
  logic [XLEN-1:0]   result_nxt;
  logic              last_step;

  always_comb begin
    rs1_signed = (op == 2'd1) || (op == 2'd2);
    rs2_signed = (op == 2'd1);
    rs1_neg    = rs1_signed & rs1_data[XLEN-1];
    rs2_neg    = rs2_signed & rs2_data[XLEN-1];
    // -0x80000000 wraps to 0x80000000, which is exactly 2^31 read unsigned
    rs1_mag    = rs1_neg ? -rs1_data : rs1_data;
    rs2_mag    = rs2_neg ? -rs2_data : rs2_data;

    addend     = mplier[0] ? mcand : '0;
    acc_nxt    = acc + addend;
    product    = neg_q ? -acc_nxt : acc_nxt;
    result_nxt = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

`ifdef MUL_EARLY_OUT_EN
    last_step  = (cnt == 6'd31) || (mplier[XLEN-1:1] == '0);
`else
    last_step  = (cnt == 6'd31);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg_q  <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q   <= op;
            mcand  <= {{XLEN{1'b0}}, rs1_mag};
            mplier <= rs2_mag;
            neg_q  <= rs1_neg ^ rs2_neg;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
          if (last_step) begin
            result <= result_nxt;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
